// File: rtl/lsu_bus_bridge_pkg.sv
// Shared load/store definitions: funct3 size codes, bridge FSM states and
// helpers for access legality and byte-lane selection.
package lsu_bus_bridge_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } lsu_state_e;

  function automatic logic f3_legal(input logic [2:0] f3);
    logic ok;
    case (f3)
      F3_B, F3_H, F3_W, F3_BU, F3_HU: ok = 1'b1;
      default:                        ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic f3_aligned(input logic [2:0] f3, input logic [1:0] off);
    logic ok;
    case (f3)
      F3_H, F3_HU: ok = ~off[0];
      F3_W:        ok = (off == 2'b00);
      default:     ok = 1'b1;
    endcase
    return ok;
  endfunction

  function automatic logic [3:0] be_gen(input logic [2:0] f3, input logic [1:0] off);
    logic [3:0] be;
    case (f3)
      F3_B, F3_BU: be = 4'b0001 << off;
      F3_H, F3_HU: be = 4'b0011 << off;
      F3_W:        be = 4'b1111;
      default:     be = 4'b0000;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/lsu_bus_bridge_if.sv
// Handshaked external data bus: req/gnt request phase, rvalid response phase.
interface lsu_bus_bridge_if #(
  parameter int ADDR_W = 32
);
  logic              bus_req;
  logic              bus_we;
  logic [ADDR_W-1:0] bus_addr;
  logic [3:0]        bus_be;
  logic [31:0]       bus_wdata;
  logic              bus_gnt;
  logic              bus_rvalid;
  logic [31:0]       bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    input  bus_gnt, bus_rvalid, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    output bus_gnt, bus_rvalid, bus_rdata
  );
endinterface

// File: rtl/lsu_bus_bridge_align.sv
// Byte-lane logic: store byte enables / lane replication, and load
// extraction with sign or zero extension.
module lsu_align
  import lsu_bus_bridge_pkg::*;
(
  input  logic [2:0]  st_funct3,
  input  logic [1:0]  st_off,
  input  logic [31:0] st_wdata,
  output logic [3:0]  st_be,
  output logic [31:0] st_wdata_rep,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_off,
  input  logic [31:0] ld_rdata,
  output logic [31:0] ld_data
);

  logic [31:0] shifted;

  always_comb begin
    st_be = be_gen(st_funct3, st_off);
    case (st_funct3)
      F3_B, F3_BU: st_wdata_rep = {4{st_wdata[7:0]}};
      F3_H, F3_HU: st_wdata_rep = {2{st_wdata[15:0]}};
      default:     st_wdata_rep = st_wdata;
    endcase
  end

  always_comb begin
    shifted = ld_rdata >> {ld_off, 3'b000};
    case (ld_funct3)
      F3_B:    ld_data = {{24{shifted[7]}}, shifted[7:0]};
      F3_BU:   ld_data = {24'h000000, shifted[7:0]};
      F3_H:    ld_data = {{16{shifted[15]}}, shifted[15:0]};
      F3_HU:   ld_data = {16'h0000, shifted[15:0]};
      default: ld_data = shifted;
    endcase
  end

endmodule

// File: rtl/lsu_bus_bridge.sv
// Load/store bridge: accepts one core memory op, runs a single req/gnt/rvalid
// bus transaction with a WAIT timeout, and stalls the core until completion.
module lsu_bus_bridge
  import lsu_bus_bridge_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int ADDR_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              core_valid,
  input  logic              core_we,
  input  logic [2:0]        core_funct3,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [31:0]       core_wdata,
  output logic              core_stall,
  output logic              core_done,
  output logic [31:0]       core_rdata,
  output logic              core_err,
  lsu_bus_bridge_if.master  bus
);

  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

  lsu_state_e        state_q, state_d;
  logic              we_q, we_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [1:0]        off_q, off_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [3:0]        be_q, be_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;
  logic [7:0]        cnt_q, cnt_d;

  logic [3:0]  st_be;
  logic [31:0] st_wdata_rep;
  logic [31:0] ld_data;
  logic        op_ok;

  // Store lanes come from the live core inputs (latched on accept); load
  // extraction uses the latched size/offset of the op in flight.
  lsu_align u_align (
    .st_funct3    (core_funct3),
    .st_off       (core_addr[1:0]),
    .st_wdata     (core_wdata),
    .st_be        (st_be),
    .st_wdata_rep (st_wdata_rep),
    .ld_funct3    (funct3_q),
    .ld_off       (off_q),
    .ld_rdata     (bus.bus_rdata),
    .ld_data      (ld_data)
  );

  assign op_ok = f3_legal(core_funct3) & f3_aligned(core_funct3, core_addr[1:0]);

  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    funct3_d   = funct3_q;
    off_d      = off_q;
    addr_d     = addr_q;
    be_d       = be_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    cnt_d      = cnt_q;
    core_stall = 1'b0;
    core_done  = 1'b0;
    core_err   = 1'b0;

    case (state_q)
      S_IDLE: begin
        cnt_d = 8'd0;
        err_d = 1'b0;
        if (core_valid) begin
          if (op_ok) begin
            we_d       = core_we;
            funct3_d   = core_funct3;
            off_d      = core_addr[1:0];
            addr_d     = {core_addr[ADDR_W-1:2], 2'b00};
            be_d       = st_be;
            wdata_d    = st_wdata_rep;
            state_d    = S_REQ;
            core_stall = 1'b1;
          end else begin
            core_err = 1'b1;
          end
        end
      end
      S_REQ: begin
        core_stall = 1'b1;
        if (bus.bus_gnt) begin
          if (bus.bus_rvalid) begin
            state_d = S_DONE;
            if (!we_q) rdata_d = ld_data;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        core_stall = 1'b1;
        cnt_d      = cnt_q + 8'd1;
        // A response on the final allowed cycle still counts as success.
        if (bus.bus_rvalid) begin
          state_d = S_DONE;
          if (!we_q) rdata_d = ld_data;
        end else if (cnt_q == TIMEOUT_LAST) begin
          state_d = S_DONE;
          err_d   = 1'b1;
        end
      end
      S_DONE: begin
        core_done = 1'b1;
        core_err  = err_q;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      we_q     <= 1'b0;
      funct3_q <= 3'b000;
      off_q    <= 2'b00;
      addr_q   <= '0;
      be_q     <= 4'b0000;
      wdata_q  <= 32'h0;
      rdata_q  <= 32'h0;
      err_q    <= 1'b0;
      cnt_q    <= 8'd0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      funct3_q <= funct3_d;
      off_q    <= off_d;
      addr_q   <= addr_d;
      be_q     <= be_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.bus_req   = (state_q == S_REQ);
  assign bus.bus_we    = (state_q == S_REQ) & we_q;
  assign bus.bus_addr  = addr_q;
  assign bus.bus_be    = be_q;
  assign bus.bus_wdata = wdata_q;
  assign core_rdata    = rdata_q;

endmodule

// File: tb/tb_lsu_bus_bridge.sv
// Directed bench for lsu_bus_bridge: loads, stores, alignment errors,
// gnt back-pressure, WAIT timeout and reset in mid-transaction.
module tb_lsu_bus_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        core_valid;
  logic        core_we;
  logic [2:0]  core_funct3;
  logic [31:0] core_addr;
  logic [31:0] core_wdata;
  logic        core_stall;
  logic        core_done;
  logic [31:0] core_rdata;
  logic        core_err;
  int          checks = 0;
  int          errors = 0;
  int          stall_cyc;

  lsu_bus_bridge_if #(.ADDR_W(32)) bif ();

  lsu_bus_bridge #(.TIMEOUT(4), .ADDR_W(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .core_valid  (core_valid),
    .core_we     (core_we),
    .core_funct3 (core_funct3),
    .core_addr   (core_addr),
    .core_wdata  (core_wdata),
    .core_stall  (core_stall),
    .core_done   (core_done),
    .core_rdata  (core_rdata),
    .core_err    (core_err),
    .bus         (bif)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Load that is granted and answered in its REQ cycle (3-cycle op).
  task automatic load_fast(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] rdata, input logic [31:0] exp_addr,
                           input logic [3:0] exp_be, input logic [31:0] exp_data);
    core_valid = 1'b1; core_we = 1'b0; core_funct3 = f3; core_addr = addr;
    tick();
    core_valid = 1'b0;
    #1;
    chk({tag, "_addr"}, bif.bus_addr, exp_addr);
    chk({tag, "_be"}, 32'(bif.bus_be), 32'(exp_be));
    bif.bus_gnt = 1'b1; bif.bus_rvalid = 1'b1; bif.bus_rdata = rdata;
    tick();
    bif.bus_gnt = 1'b0; bif.bus_rvalid = 1'b0;
    #1;
    chk({tag, "_done"}, 32'(core_done), 32'd1);
    chk({tag, "_rdata"}, core_rdata, exp_data);
    $display("op %s addr=%h rdata=%h", tag, addr, core_rdata);
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; core_valid = 1'b0; core_we = 1'b0; core_funct3 = 3'b000;
    core_addr = 32'h0; core_wdata = 32'h0;
    bif.bus_gnt = 1'b0; bif.bus_rvalid = 1'b0; bif.bus_rdata = 32'h0;
    repeat (2) tick();
    #1;
    chk("rst_req", 32'(bif.bus_req), 32'd0);
    chk("rst_stall", 32'(core_stall), 32'd0);
    chk("rst_done", 32'(core_done), 32'd0);
    chk("rst_rdata", core_rdata, 32'h0);
    chk("rst_be", 32'(bif.bus_be), 32'h0);
    rst = 1'b0;
    tick();

    // LW 0x100: gnt in cycle 1, rvalid in cycle 3, four stall cycles
    stall_cyc = 0;
    core_valid = 1'b1; core_we = 1'b0; core_funct3 = 3'b010; core_addr = 32'h100;
    #1;
    chk("lw_stall_accept", 32'(core_stall), 32'd1);
    stall_cyc += int'(core_stall);
    tick();
    core_valid = 1'b0;
    #1;
    chk("lw_req", 32'(bif.bus_req), 32'd1);
    chk("lw_be", 32'(bif.bus_be), 32'hF);
    chk("lw_addr", bif.bus_addr, 32'h100);
    chk("lw_we", 32'(bif.bus_we), 32'd0);
    stall_cyc += int'(core_stall);
    bif.bus_gnt = 1'b1;
    tick();
    bif.bus_gnt = 1'b0;
    #1;
    chk("lw_wait_req", 32'(bif.bus_req), 32'd0);
    stall_cyc += int'(core_stall);
    tick();
    bif.bus_rvalid = 1'b1; bif.bus_rdata = 32'hDEADBEEF;
    #1;
    stall_cyc += int'(core_stall);
    tick();
    bif.bus_rvalid = 1'b0;
    #1;
    chk("lw_done", 32'(core_done), 32'd1);
    chk("lw_rdata", core_rdata, 32'hDEADBEEF);
    chk("lw_err", 32'(core_err), 32'd0);
    stall_cyc += int'(core_stall);
    chk("lw_stall_cycles", 32'(stall_cyc), 32'd4);
    $display("op LW addr=00000100 rdata=%h stall_cycles=%0d", core_rdata, stall_cyc);
    tick();
    #1;
    chk("lw_done_pulse", 32'(core_done), 32'd0);
    tick();

    load_fast("lb",  3'b000, 32'h103, 32'h80FFFF00, 32'h100, 4'b1000, 32'hFFFFFF80);
    load_fast("lbu", 3'b100, 32'h103, 32'h80FFFF00, 32'h100, 4'b1000, 32'h00000080);
    load_fast("lh",  3'b001, 32'h102, 32'h80010000, 32'h100, 4'b1100, 32'hFFFF8001);
    load_fast("lhu", 3'b101, 32'h102, 32'h80010000, 32'h100, 4'b1100, 32'h00008001);

    // SH 0x202 with gnt held low for 5 REQ cycles
    core_valid = 1'b1; core_we = 1'b1; core_funct3 = 3'b001;
    core_addr = 32'h202; core_wdata = 32'h1234ABCD;
    tick();
    core_valid = 1'b0; core_we = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("sh_req", 32'(bif.bus_req), 32'd1);
      chk("sh_addr", bif.bus_addr, 32'h200);
      chk("sh_be", 32'(bif.bus_be), 32'hC);
      chk("sh_wdata", bif.bus_wdata, 32'hABCDABCD);
      chk("sh_we", 32'(bif.bus_we), 32'd1);
      tick();
    end
    bif.bus_gnt = 1'b1;
    tick();
    bif.bus_gnt = 1'b0;
    #1;
    chk("sh_wait_req", 32'(bif.bus_req), 32'd0);
    bif.bus_rvalid = 1'b1; bif.bus_rdata = 32'h55555555;
    tick();
    bif.bus_rvalid = 1'b0;
    #1;
    chk("sh_done", 32'(core_done), 32'd1);
    chk("sh_rdata_kept", core_rdata, 32'h00008001);
    $display("op SH addr=00000202 bus_wdata=%h", bif.bus_wdata);
    tick();

    // Misaligned LW and illegal funct3: error pulse, no bus op, no stall
    core_valid = 1'b1; core_funct3 = 3'b010; core_addr = 32'h101;
    #1;
    chk("mis_err", 32'(core_err), 32'd1);
    chk("mis_stall", 32'(core_stall), 32'd0);
    tick();
    core_valid = 1'b0;
    #1;
    chk("mis_req", 32'(bif.bus_req), 32'd0);
    chk("mis_err_clear", 32'(core_err), 32'd0);
    $display("op LW addr=00000101 misaligned");
    core_valid = 1'b1; core_funct3 = 3'b011; core_addr = 32'h100;
    #1;
    chk("ill_err", 32'(core_err), 32'd1);
    chk("ill_stall", 32'(core_stall), 32'd0);
    tick();
    core_valid = 1'b0;
    #1;
    chk("ill_req", 32'(bif.bus_req), 32'd0);
    $display("op funct3=011 illegal");
    tick();

    // Timeout: granted, never answered; done+err after 4 WAIT cycles
    core_valid = 1'b1; core_funct3 = 3'b010; core_addr = 32'h300;
    tick();
    core_valid = 1'b0;
    bif.bus_gnt = 1'b1;
    tick();
    bif.bus_gnt = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("to_wait_done", 32'(core_done), 32'd0);
      chk("to_wait_stall", 32'(core_stall), 32'd1);
      tick();
    end
    #1;
    chk("to_done", 32'(core_done), 32'd1);
    chk("to_err", 32'(core_err), 32'd1);
    chk("to_rdata_kept", core_rdata, 32'h00008001);
    $display("op LW addr=00000300 timeout err=%0d", core_err);
    tick();
    bif.bus_rvalid = 1'b1; bif.bus_rdata = 32'h12345678;
    #1;
    chk("late_done", 32'(core_done), 32'd0);
    chk("late_stall", 32'(core_stall), 32'd0);
    tick();
    bif.bus_rvalid = 1'b0;
    #1;
    chk("late_rdata", core_rdata, 32'h00008001);
    chk("late_done2", 32'(core_done), 32'd0);
    tick();

    // Reset asserted while in WAIT
    core_valid = 1'b1; core_funct3 = 3'b010; core_addr = 32'h400;
    tick();
    core_valid = 1'b0;
    bif.bus_gnt = 1'b1;
    tick();
    bif.bus_gnt = 1'b0;
    #1;
    chk("rw_stall_pre", 32'(core_stall), 32'd1);
    rst = 1'b1;
    #1;
    chk("rw_req", 32'(bif.bus_req), 32'd0);
    chk("rw_stall", 32'(core_stall), 32'd0);
    chk("rw_done", 32'(core_done), 32'd0);
    chk("rw_rdata", core_rdata, 32'h0);
    tick();
    rst = 1'b0;
    tick();
    #1;
    chk("rw_no_done", 32'(core_done), 32'd0);
    $display("op LW addr=00000400 reset in WAIT");
    tick();

    load_fast("lw_after_rst", 3'b010, 32'h500, 32'hCAFEF00D, 32'h500, 4'b1111, 32'hCAFEF00D);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
